// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcode map, ir field positions,
// FSM state encoding and opcode classes.
package cpu_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    // R-type ALU class spans 00000 up to and including OPC_RTYPE_LAST
    localparam logic [4:0] OPC_RTYPE_LAST = 5'b01011;
    localparam logic [4:0] OPC_MUL        = 5'b01111;
    localparam logic [4:0] OPC_DIV        = 5'b10000;
    localparam logic [4:0] OPC_NEG        = 5'b10001;
    localparam logic [4:0] OPC_NOT        = 5'b10010;
    localparam logic [4:0] OPC_NOP        = 5'b11010;
    localparam logic [4:0] OPC_HALT       = 5'b11011;
    localparam logic [4:0] OPC_NONE       = 5'b00000;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_EX1  = 4'd4,
        S_EX2  = 4'd5,
        S_EX3  = 4'd6,
        S_EX4  = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer-to-datapath bundle: instruction register in, control strobes out.
interface control_sequencer_if;
    // No valid/ready: every strobe is a single-cycle level that the datapath acts on
    // at the rising edge ending the cycle it is high; ir is held by the datapath.
    logic [31:0] ir;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic [4:0]  opcode;
    logic        halted;
    logic        illegal;

    modport master (
        input  ir,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
        output Yin, Zin, Zhighout, Zlowout, HIin, LOin,
        output Rout, Rin, opcode, halted, illegal
    );

    modport slave (
        output ir,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
        input  Yin, Zin, Zhighout, Zlowout, HIin, LOin,
        input  Rout, Rin, opcode, halted, illegal
    );
endinterface

// File: rtl/ir_decode.sv
// Combinational instruction decode: opcode class, register one-hots, illegal flag.
// With CTRL_MULDIV_EN undefined, MUL/DIV decode as illegal.
module ir_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output op_class_t   op_class,
    output logic [15:0] ra_oh,
    output logic [15:0] rb_oh,
    output logic [15:0] rc_oh,
    output logic        illegal
);
    logic [4:0] op;
    logic       unused_low;

    assign op         = ir[OPC_HI:OPC_LO];
    assign unused_low = ^ir[RC_LO-1:0];

    always_comb begin
        op_class = CLS_ILLEGAL;
        if (op <= OPC_RTYPE_LAST) begin
            op_class = CLS_RTYPE;
        end else if (op == OPC_NEG || op == OPC_NOT) begin
            op_class = CLS_UNARY;
        end else if (op == OPC_MUL || op == OPC_DIV) begin
`ifdef CTRL_MULDIV_EN
            op_class = CLS_MULDIV;
`else
            op_class = CLS_ILLEGAL;
`endif
        end else if (op == OPC_NOP) begin
            op_class = CLS_NOP;
        end else if (op == OPC_HALT) begin
            op_class = CLS_HALT;
        end
    end

    assign illegal = (op_class == CLS_ILLEGAL);
    assign ra_oh   = reg_onehot(ir[RA_HI:RA_LO]);
    assign rb_oh   = reg_onehot(ir[RB_HI:RB_LO]);
    assign rc_oh   = reg_onehot(ir[RC_HI:RC_LO]);
endmodule

// File: rtl/control_sequencer.sv
// Moore fetch/execute control sequencer; strobes decode from state plus ir.
// Optional feature macro: CTRL_MULDIV_EN (MUL/DIV sequencing, EX4, HIin/LOin/Zhighout).
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       run,
    control_sequencer_if.master        bus,
    output state_t                     dbg_state
);
    state_t      state;
    state_t      state_eoi;
    logic        illegal_q;
    op_class_t   op_class;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic        dec_illegal;
    logic [4:0]  alu_op;

    ir_decode u_ir_decode (
        .ir       (bus.ir),
        .op_class (op_class),
        .ra_oh    (ra_oh),
        .rb_oh    (rb_oh),
        .rc_oh    (rc_oh),
        .illegal  (dec_illegal)
    );

    assign alu_op    = bus.ir[OPC_HI:OPC_LO];
    assign state_eoi = run ? S_T0 : S_IDLE;
    assign dbg_state = state;

    // run only matters in IDLE and at the end-of-instruction transition
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= (state == S_T2) && dec_illegal;
            case (state)
                S_IDLE: if (run) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   state <= S_T2;
                S_T2: begin
                    case (op_class)
                        CLS_HALT:             state <= S_HALT;
                        CLS_NOP, CLS_ILLEGAL: state <= state_eoi;
                        default:              state <= S_EX1;
                    endcase
                end
                S_EX1:  state <= S_EX2;
                S_EX2:  state <= (op_class == CLS_UNARY) ? state_eoi : S_EX3;
`ifdef CTRL_MULDIV_EN
                S_EX3:  state <= (op_class == CLS_MULDIV) ? S_EX4 : state_eoi;
                S_EX4:  state <= state_eoi;
`else
                S_EX3:  state <= state_eoi;
`endif
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Read     = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zhighout = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Rout     = 16'h0000;
        bus.Rin      = 16'h0000;
        bus.opcode   = OPC_NONE;
        bus.halted   = (state == S_HALT);
        bus.illegal  = illegal_q;
        case (state)
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            S_EX1: begin
                case (op_class)
                    CLS_RTYPE: begin bus.Rout = rb_oh; bus.Yin = 1'b1; end
                    CLS_UNARY: begin bus.Rout = rb_oh; bus.Zin = 1'b1; bus.opcode = alu_op; end
`ifdef CTRL_MULDIV_EN
                    CLS_MULDIV: begin bus.Rout = ra_oh; bus.Yin = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_EX2: begin
                case (op_class)
                    CLS_RTYPE: begin bus.Rout = rc_oh; bus.Zin = 1'b1; bus.opcode = alu_op; end
                    CLS_UNARY: begin bus.Zlowout = 1'b1; bus.Rin = ra_oh; end
`ifdef CTRL_MULDIV_EN
                    CLS_MULDIV: begin bus.Rout = rb_oh; bus.Zin = 1'b1; bus.opcode = alu_op; end
`endif
                    default: ;
                endcase
            end
            S_EX3: begin
                case (op_class)
                    CLS_RTYPE: begin bus.Zlowout = 1'b1; bus.Rin = ra_oh; end
`ifdef CTRL_MULDIV_EN
                    CLS_MULDIV: begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
`endif
                    default: ;
                endcase
            end
`ifdef CTRL_MULDIV_EN
            S_EX4: begin
                bus.Zhighout = 1'b1; bus.HIin = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected output vectors
// are queued by the driver and compared at each falling edge.
module tb_control_sequencer;
  import cpu_pkg::*;

  localparam int W = 57;
  localparam logic [13:0] M_PCOUT = 14'h2000, M_PCIN = 14'h1000, M_INCPC = 14'h0800,
                          M_MARIN = 14'h0400, M_MDRIN = 14'h0200, M_MDROUT = 14'h0100,
                          M_READ = 14'h0080, M_IRIN = 14'h0040, M_YIN = 14'h0020,
                          M_ZIN = 14'h0010, M_ZHIGH = 14'h0008, M_ZLOW = 14'h0004,
                          M_HIIN = 14'h0002, M_LOIN = 14'h0001;
`ifdef CTRL_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  // clock / reset
  logic   clock = 1'b0;
  logic   clear;
  logic   run;
  state_t dbg_state;
  always #5 clock = ~clock;

  control_sequencer_if bus();

  control_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .run       (run),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic [W-1:0] seq_q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  logic         pend_illegal = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ev(input state_t st, input logic [13:0] m,
                                      input logic [15:0] ro, input logic [15:0] ri,
                                      input logic [4:0] opc, input logic hl);
    return {st, m, ro, ri, opc, hl, 1'b0};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0000};
  endfunction

  // one clock cycle: queue what this cycle must show, then advance to next posedge+1
  task automatic cyc(input logic [W-1:0] v, input string tag);
    exp_q.push_back(v | W'(pend_illegal));
    tag_q.push_back(tag);
    pend_illegal = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic push_fetch();
    seq_q.push_back(ev(S_T0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 16'h0, 16'h0, 5'h0, 1'b0));
    seq_q.push_back(ev(S_T1, M_ZLOW | M_PCIN | M_READ | M_MDRIN, 16'h0, 16'h0, 5'h0, 1'b0));
    seq_q.push_back(ev(S_T2, M_MDROUT | M_IRIN, 16'h0, 16'h0, 5'h0, 1'b0));
  endtask

  // reference model of the execute phase
  task automatic build_exec(input logic [31:0] instr, output logic ill);
    logic [4:0]  op;
    logic [15:0] ra, rb, rc;
    op = instr[31:27];
    ra = 16'h0001 << instr[26:23];
    rb = 16'h0001 << instr[22:19];
    rc = 16'h0001 << instr[18:15];
    ill = 1'b0;
    if (op <= 5'd11) begin
      seq_q.push_back(ev(S_EX1, M_YIN, rb, 16'h0, 5'h0, 1'b0));
      seq_q.push_back(ev(S_EX2, M_ZIN, rc, 16'h0, op, 1'b0));
      seq_q.push_back(ev(S_EX3, M_ZLOW, 16'h0, ra, 5'h0, 1'b0));
    end else if (op == 5'd17 || op == 5'd18) begin
      seq_q.push_back(ev(S_EX1, M_ZIN, rb, 16'h0, op, 1'b0));
      seq_q.push_back(ev(S_EX2, M_ZLOW, 16'h0, ra, 5'h0, 1'b0));
    end else if ((op == 5'd15 || op == 5'd16) && MULDIV_EN) begin
      seq_q.push_back(ev(S_EX1, M_YIN, ra, 16'h0, 5'h0, 1'b0));
      seq_q.push_back(ev(S_EX2, M_ZIN, rb, 16'h0, op, 1'b0));
      seq_q.push_back(ev(S_EX3, M_ZLOW | M_LOIN, 16'h0, 16'h0, 5'h0, 1'b0));
      seq_q.push_back(ev(S_EX4, M_ZHIGH | M_HIIN, 16'h0, 16'h0, 5'h0, 1'b0));
    end else if (op != 5'd26) begin
      ill = 1'b1;
    end
  endtask

  // drive one instruction; drop_at = sequence index where run falls (-1 keeps run high)
  task automatic issue(input string tag, input logic [31:0] instr, input bit from_idle,
                       input int drop_at);
    logic ill;
    seq_q.delete();
    bus.ir = instr;
    if (from_idle) begin
      run = 1'b1;
      seq_q.push_back(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0));
    end
    push_fetch();
    build_exec(instr, ill);
    for (int k = 0; k < seq_q.size(); k++) begin
      if (k == drop_at) run = 1'b0;
      cyc(seq_q[k], tag);
    end
    if (ill) pend_illegal = 1'b1;
  endtask

  task automatic halt_seq();
    seq_q.delete();
    bus.ir = mk_ir(5'd27, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'h0);
    push_fetch();
    for (int k = 0; k < seq_q.size(); k++) cyc(seq_q[k], "halt_fetch");
    for (int k = 0; k < 20; k++) cyc(ev(S_HALT, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1), "halt_hold");
    clear = 1'b0;
    cyc(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0), "halt_clear");
    clear = 1'b1;
    run = 1'b0;
    cyc(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0), "halt_idle");
  endtask

  task automatic clear_mid();
    seq_q.delete();
    bus.ir = 32'h2A2B8000;
    run = 1'b1;
    seq_q.push_back(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0));
    push_fetch();
    seq_q.push_back(ev(S_EX1, M_YIN, 16'h0020, 16'h0, 5'h0, 1'b0));
    for (int k = 0; k < seq_q.size(); k++) cyc(seq_q[k], "clr_pre");
    clear = 1'b0;
    cyc(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0), "clr_ex2");
    clear = 1'b1;
    run = 1'b0;
    cyc(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0), "clr_idle");
    cyc(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0), "clr_no_rin");
  endtask

  // monitor: bus exclusivity every cycle, scoreboard pop when an entry is due
  always @(negedge clock) begin
    logic [W-1:0] obs;
    logic [W-1:0] e;
    string        t;
    int           drv;
    obs = {dbg_state, bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
           bus.Read, bus.IRin, bus.Yin, bus.Zin, bus.Zhighout, bus.Zlowout, bus.HIin,
           bus.LOin, bus.Rout, bus.Rin, bus.opcode, bus.halted, bus.illegal};
    drv = int'(bus.PCout) + int'(bus.MDRout) + int'(bus.Zlowout) + int'(bus.Zhighout)
        + int'(|bus.Rout);
    check_eq("bus_excl", {63'b0, ($onehot0(bus.Rout) && (drv <= 1))}, 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, 64'(obs), 64'(e));
    end
  end

  logic [4:0] ill_ops[7] = '{5'd12, 5'd13, 5'd14, 5'd19, 5'd25, 5'd28, 5'd31};

  initial begin
    clear = 1'b0;
    run = 1'b0;
    bus.ir = 32'h0;
    @(posedge clock);
    #1;
    cyc(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0), "rst_idle");
    run = 1'b1;
    bus.ir = $urandom;
    cyc(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0), "rst_hold_run");
    clear = 1'b1;
    run = 1'b0;
    cyc(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0), "rst_release");
    cyc(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0), "idle_no_run");

    issue("add_ex", 32'h2A2B8000, 1'b1, -1);
    issue("rtype_same_reg", mk_ir(5'd0, 4'd9, 4'd9, 4'd9), 1'b0, -1);
    issue("rtype_last", mk_ir(5'd11, 4'd15, 4'd0, 4'd14), 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] w;
      w = mk_ir(5'($urandom_range(0, 11)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))) | ($urandom & 32'h7FFF);
      issue("rtype_rand", w, 1'b0, -1);
    end
    issue("neg", mk_ir(5'd17, 4'd3, 4'd12, 4'd0), 1'b0, -1);
    issue("not", mk_ir(5'd18, 4'd15, 4'd0, 4'd5), 1'b0, -1);
    issue("nop", mk_ir(5'd26, 4'd1, 4'd2, 4'd3), 1'b0, -1);
    issue("mul", mk_ir(5'd15, 4'd2, 4'd3, 4'd0), 1'b0, -1);
    issue("div", mk_ir(5'd16, 4'd7, 4'd1, 4'd0), 1'b0, -1);
    for (int i = 0; i < 7; i++) begin
      issue("illegal", mk_ir(ill_ops[i], 4'd4, 4'd5, 4'd6), 1'b0, -1);
    end
    issue("add_run_drop_ex1", 32'h2A2B8000, 1'b0, 3);
    issue("rerun", mk_ir(5'd1, 4'd6, 4'd7, 4'd8), 1'b1, -1);
    halt_seq();
    clear_mid();
    issue("after_clear", mk_ir(5'd3, 4'd1, 4'd2, 4'd3), 1'b1, 4);
    cyc(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0), "final_idle");
    cyc(ev(S_IDLE, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0), "final_idle");
    check_eq("q_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  in  1  single system clock; all state updates on its rising edge.
REQ-002 clear  in  1  asynchronous, active-low reset.
REQ-003 run  in  1  level enable; sequencer fetches while high.
REQ-004 ir  in  32  instruction register contents from datapath; fields opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
REQ-005 PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin  out  1 each  datapath strobes, active-high.
REQ-006 Rout  out  16  one-hot register-to-bus enable, bit n drives Rn.
REQ-007 Rin  out  16  one-hot register load enable, bit n loads Rn.
REQ-008 opcode  out  5  ALU operation; 5'b00000 when no ALU op is in progress.
REQ-009 halted  out  1  high while in HALT state.
REQ-010 illegal  out  1  one-cycle pulse on decode of an unassigned opcode.

Function
REQ-011 Moore FSM; every output is decoded from the state register plus ir only; each step lasts exactly one clock.
REQ-012 States: IDLE, T0, T1, T2, EX1, EX2, EX3, EX4, HALT.
REQ-013 IDLE: all outputs 0; go to T0 when run=1, otherwise stay in IDLE.
REQ-014 T0: PCout, MARin, IncPC, Zin =1.
REQ-015 T1: Zlowout, PCin, Read, MDRin =1; memory data is valid within this cycle.
REQ-016 T2: MDRout, IRin =1; ir is valid from EX1 onward.
REQ-017 R-type ALU class (opcodes 00000-01011):
- EX1: Rout[Rb], Yin.
- EX2: Rout[Rc], Zin, opcode=ir[31:27].
- EX3: Zlowout, Rin[Ra].
REQ-018 Unary class (NEG 10001, NOT 10010):
- EX1: Rout[Rb], Zin, opcode=ir[31:27].
- EX2: Zlowout, Rin[Ra].
REQ-019 MUL 01111 / DIV 10000:
- EX1: Rout[Ra], Yin.
- EX2: Rout[Rb], Zin, opcode.
- EX3: Zlowout, LOin.
- EX4: Zhighout, HIin.
REQ-020 NOP 11010: no execute step; the state after T2 is the end-of-instruction transition.
REQ-021 HALT 11011: T2 -> HALT; HALT holds all strobes 0 and halted=1 until clear is asserted.
REQ-022 Illegal opcodes: behave as NOP; illegal=1 during the cycle following T2.
REQ-023 End of instruction: go to T0 if run=1, else IDLE; run is sampled only at this point and in IDLE.
REQ-024 At most one bit of Rout is high in any cycle; at most one bus-driving strobe (PCout, MDRout, Zlowout, Zhighout, any Rout) is high in any cycle.
REQ-025 Ra=Rb=Rc is legal; register operands are not otherwise constrained.

Reset
REQ-026 clear=0 forces IDLE immediately, from any state including mid-execute, and zeroes every output (opcode=00000, halted=0, illegal=0).
REQ-027 After clear deasserts, the first fetch is T0 on the first rising edge with run=1.

Configuration
REQ-028 Macro CTRL_MULDIV_EN.
- Defined: MUL/DIV are sequenced per REQ-019.
- Undefined: opcodes 01111/10000 are illegal per REQ-022; EX4, HIin, LOin and Zhighout are tied 0.

Structure
REQ-029 Shared package cpu_pkg holds:
- opcode constants and class ranges;
- ir field bit positions;
- FSM state encoding.
REQ-030 Sub-module ir_decode (combinational): ir -> opcode class, Ra/Rb/Rc one-hot vectors, illegal flag.

Verification
REQ-031 run=1, ir=0x2A2B8000 (opcode 00101, Ra=4, Rb=5, Rc=7) -> EX1 Rout=0x0020+Yin; EX2 Rout=0x0080, Zin, opcode=00101; EX3 Zlowout, Rin=0x0010; next state T0.
REQ-032 MUL, Ra=2, Rb=3, CTRL_MULDIV_EN defined -> EX3 LOin, EX4 Zhighout+HIin; same instruction with macro undefined -> illegal pulse, no HIin/LOin.
REQ-033 HALT opcode -> halted=1 from the cycle after T2 and held 20 cycles with all strobes 0; clear pulse -> IDLE, halted=0.
REQ-034 clear asserted during EX2 of an ADD -> outputs 0 in the same cycle, state IDLE, no Rin pulse issued.
REQ-035 run dropped during EX1 -> current instruction completes, then IDLE; run reasserted -> T0 on the next edge.
REQ-036 Every cycle, for all scenarios: assert the one-hot/bus-exclusivity rule of REQ-024.
